// File: rtl/attr_int_accum_pkg.sv
// Shared defines for the attribute integer accumulator.
// Character/value widths and ASCII digit bounds.
package attr_int_accum_pkg;

  localparam int CHAR_BITES          = 8;
  localparam int ATTRIBUTE_VAL_BITES = 16;

  localparam logic [CHAR_BITES-1:0] ASCII_0 = 8'd48;
  localparam logic [CHAR_BITES-1:0] ASCII_9 = 8'd57;

endpackage

// File: rtl/attr_int_accum_char_to_int.sv
// ASCII character to integer offset ('0' maps to 0).
// Ports: char_i (ASCII in), int_o (char_i - '0', unchecked).
module attr_int_accum_char_to_int
  import attr_int_accum_pkg::*;
(
  input  logic [CHAR_BITES-1:0] char_i,
  output logic [CHAR_BITES-1:0] int_o
);

  assign int_o = char_i - ASCII_0;

endmodule

// File: rtl/attr_int_accum.sv
// Decimal attribute parser: accumulates ASCII digits into a
// saturating 16-bit value. Ports: start/char handshake in,
// val/overflow/digit_cnt result with valid/ready out, busy.
module attr_int_accum
  import attr_int_accum_pkg::*;
#(
  parameter int MAX_DIGITS = 5
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           start,
  input  logic [CHAR_BITES-1:0]          char_in,
  input  logic                           char_valid,
  output logic                           char_ready,
  output logic [ATTRIBUTE_VAL_BITES-1:0] val_out,
  output logic                           val_valid,
  input  logic                           val_ready,
  output logic                           overflow,
  output logic [2:0]                     digit_cnt,
  output logic                           busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACCUM = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam logic [2:0] MAX_CNT = 3'(MAX_DIGITS);

  logic [1:0]  state_q, state_d;
  logic [15:0] acc_q, acc_d;
  logic        ovf_q, ovf_d;
  logic [2:0]  cnt_q, cnt_d;

  logic [CHAR_BITES-1:0] dig;
  logic                  is_digit;
  logic                  xfer;
  logic [19:0]           acc_w;
  logic [19:0]           sum;
  logic [2:0]            cnt_inc;

  attr_int_accum_char_to_int u_char_to_int (
    .char_i (char_in),
    .int_o  (dig)
  );

  assign is_digit = (char_in >= ASCII_0) && (char_in <= ASCII_9);
  assign xfer     = char_valid && (state_q == ACCUM);

  // x10 as x8 + x2; 20 bits hold 65535*10+9 without wrap
  assign acc_w   = {4'b0, acc_q};
  assign sum     = (acc_w << 3) + (acc_w << 1) + {12'b0, dig};
  assign cnt_inc = cnt_q + 3'd1;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          acc_d   = '0;
          ovf_d   = 1'b0;
          cnt_d   = '0;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        if (xfer) begin
          if (is_digit) begin
            cnt_d = cnt_inc;
            // saturated value is frozen once overflow is set
            if (!ovf_q) begin
              if (sum > 20'h0FFFF) begin
                acc_d = 16'hFFFF;
                ovf_d = 1'b1;
              end else begin
                acc_d = sum[15:0];
              end
            end
            if (cnt_inc == MAX_CNT) state_d = DONE;
          end else begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (val_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  assign char_ready = (state_q == ACCUM);
  assign val_valid  = (state_q == DONE);
  assign busy       = (state_q != IDLE);
  assign val_out    = acc_q;
  assign overflow   = ovf_q;
  assign digit_cnt  = cnt_q;

endmodule

// File: tb/tb_attr_int_accum.sv
// Scoreboard bench for attr_int_accum: directed number strings,
// expected results queued and checked by a monitor on val_valid.
module tb_attr_int_accum;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [7:0]  char_in;
  logic        char_valid;
  logic        char_ready;
  logic [15:0] val_out;
  logic        val_valid;
  logic        val_ready;
  logic        overflow;
  logic [2:0]  digit_cnt;
  logic        busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] val;
    logic [2:0]  cnt;
    logic        ovf;
  } exp_t;

  exp_t sb[$];
  logic seen;

  attr_int_accum #(.MAX_DIGITS(5)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .char_in    (char_in),
    .char_valid (char_valid),
    .char_ready (char_ready),
    .val_out    (val_out),
    .val_valid  (val_valid),
    .val_ready  (val_ready),
    .overflow   (overflow),
    .digit_cnt  (digit_cnt),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // monitor: one pop per DONE episode
  initial seen = 1'b0;
  always @(negedge clk) begin
    if (reset_n && val_valid && !seen) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got val %0d expected none", val_out);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_val", val_out, e.val);
        chk("sb_cnt", digit_cnt, e.cnt);
        chk("sb_ovf", overflow, e.ovf);
      end
    end
    seen = reset_n && val_valid;
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input int v, input int c, input bit o);
    exp_t e;
    e.val = 16'(v);
    e.cnt = 3'(c);
    e.ovf = o;
    sb.push_back(e);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  task automatic send_char(input byte c);
    bit ok;
    int n;
    char_in    = c;
    char_valid = 1'b1;
    n = 0;
    do begin
      ok = char_ready;
      cyc(1);
      n++;
    end while (!ok && n < 50);
    char_valid = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got ready 0 expected 1");
    end
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_char(s[i]);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 50) begin
      cyc(1);
      n++;
    end
    chk("idle_timeout", busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n    = 1'b0;
    start      = 1'b0;
    char_in    = 8'd0;
    char_valid = 1'b0;
    val_ready  = 1'b1;
    #12;
    chk("rst_ready", char_ready, 0);
    chk("rst_valid", val_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_val", val_out, 0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    cyc(1);

    // "123 " contiguous, latency one cycle after ' '
    push(123, 3, 0);
    pulse_start();
    chk("accum_ready", char_ready, 1);
    chk("accum_busy", busy, 1);
    send_str("123 ");
    chk("lat_123", val_valid, 1);
    wait_idle();

    // largest value that fits; terminates on 5th digit
    push(65535, 5, 0);
    pulse_start();
    send_str("65535");
    chk("max_valid", val_valid, 1);
    chk("max_ready", char_ready, 0);
    wait_idle();

    push(16'hFFFF, 5, 1);
    pulse_start();
    send_str("65536");
    wait_idle();

    push(16'hFFFF, 5, 1);
    pulse_start();
    send_str("99999");
    wait_idle();

    push(42, 5, 0);
    pulse_start();
    send_str("00042");
    chk("maxd_ready", char_ready, 0);
    chk("maxd_valid", val_valid, 1);
    wait_idle();

    push(0, 0, 0);
    pulse_start();
    send_str("x");
    chk("x_valid", val_valid, 1);
    wait_idle();

    // gap in char_valid, then hold result in DONE
    push(78, 2, 0);
    pulse_start();
    send_str("7");
    cyc(4);
    send_str("8");
    val_ready = 1'b0;
    send_str(" ");
    for (int i = 0; i < 3; i++) begin
      chk("hold_valid", val_valid, 1);
      chk("hold_val", val_out, 78);
      chk("hold_cnt", digit_cnt, 2);
      start = 1'b1;
      cyc(1);
      start = 1'b0;
    end
    chk("hold_end_val", val_out, 78);
    val_ready = 1'b1;
    cyc(1);
    chk("release_idle", busy, 0);

    // start during ACCUM must not clear the partial value
    push(12, 2, 0);
    pulse_start();
    send_str("1");
    pulse_start();
    send_str("2 ");
    wait_idle();

    // async reset mid-ACCUM
    pulse_start();
    send_str("45");
    #2 reset_n = 1'b0;
    #1;
    chk("arst_val", val_out, 0);
    chk("arst_cnt", digit_cnt, 0);
    chk("arst_busy", busy, 0);
    chk("arst_ready", char_ready, 0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    char_in    = "9";
    char_valid = 1'b1;
    cyc(3);
    char_valid = 1'b0;
    chk("nostart_busy", busy, 0);
    chk("nostart_val", val_out, 0);
    push(9, 1, 0);
    pulse_start();
    send_str("9 ");
    wait_idle();

    cyc(3);
    chk("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/attr_int_accum.md
ATTR_INT_ACCUM -- requirements
Module: attr_int_accum

Interface
REQ-001 SHALL have parameter MAX_DIGITS, default 5, meaning the maximum number of decimal digits accumulated before forced termination.
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port start  input  1  one-cycle pulse beginning a new number parse.
REQ-005 SHALL have port char_in  input  `CHAR_BITES (8)  ASCII character from the tokenizer stream.
REQ-006 SHALL have port char_valid  input  1  char_in is valid this cycle.
REQ-007 SHALL have port char_ready  output  1  block accepts char_in this cycle.
REQ-008 SHALL have port val_out  output  `ATTRIBUTE_VAL_BITES (16)  accumulated integer value.
REQ-009 SHALL have port val_valid  output  1  val_out, overflow and digit_cnt are final.
REQ-010 SHALL have port val_ready  input  1  consumer takes the result.
REQ-011 SHALL have port overflow  output  1  value exceeded 16'hFFFF and was saturated.
REQ-012 SHALL have port digit_cnt  output  3  number of digits consumed (0..MAX_DIGITS).
REQ-013 SHALL have port busy  output  1  high in ACCUM or DONE.

Function
REQ-014 SHALL implement FSM states IDLE, ACCUM, DONE.
REQ-015 IDLE: char_ready=0, val_valid=0; start -> ACCUM, clearing accumulator, overflow, digit_cnt the same edge.
REQ-016 start in ACCUM or DONE SHALL be ignored.
REQ-017 ACCUM: char_ready=1; a char transfers only when char_valid && char_ready.
REQ-018 Digit classification SHALL use char_to_int plus a range check 48..57; digit value is char_to_int output.
REQ-019 Accepted digit SHALL update acc = acc*10 + digit, computed in 20 bits; result >16'hFFFF -> acc=16'hFFFF and overflow=1 (sticky).
REQ-020 Once overflow=1, further digits SHALL be consumed without changing acc.
REQ-021 Accepted non-digit SHALL be consumed as terminator, leave acc unchanged, -> DONE next edge.
REQ-022 Accepted digit making digit_cnt reach MAX_DIGITS SHALL be added, then -> DONE (no terminator consumed).
REQ-023 Non-digit as first char SHALL give val_out=0, digit_cnt=0, overflow=0.
REQ-024 DONE: char_ready=0, val_valid=1; val_out/overflow/digit_cnt stable until val_ready; val_valid && val_ready -> IDLE next edge.
REQ-025 Latency: val_valid SHALL assert the cycle after the terminating transfer.
REQ-026 val_out SHALL reflect acc in every state; consumers sample only on val_valid.

Reset
REQ-027 reset_n low SHALL asynchronously force IDLE, acc=0, overflow=0, digit_cnt=0, val_valid=0, char_ready=0, busy=0.
REQ-028 Reset mid-ACCUM or mid-DONE SHALL discard the partial result; no val_valid after release until a new start.
REQ-029 Release SHALL be synchronous to clk; first start accepted on the first edge after release.

Structure
REQ-030 CHAR_BITES, ATTRIBUTE_VAL_BITES and ASCII constants '0'=48, '9'=57 SHALL live in the shared defines package; FSM state encoding stays local.
REQ-031 SHALL instantiate exactly one char_to_int sub-module; multiply-by-10 as (acc<<3)+(acc<<1).

Verification
REQ-032 start, chars "123 " contiguous -> val_out=123, digit_cnt=3, overflow=0, val_valid 1 cycle after ' '.
REQ-033 start, "65535;" -> 65535, overflow=0; start, "65536;" -> 16'hFFFF, overflow=1.
REQ-034 start, "00042" (MAX_DIGITS=5) -> DONE after 5th digit, val_out=42, char_ready=0 next cycle; "x" first -> val_out=0, digit_cnt=0.
REQ-035 "7" then char_valid low 4 cycles then "8 " -> 78; val_ready held low 3 cycles in DONE -> outputs stable, start pulses ignored.
REQ-036 reset_n low after "45" in ACCUM -> all outputs reset immediately; after release "9 " without start is not accepted; start,"9 " -> 9.
